// File: rtl/regfile_write_arbiter.sv
// Arbitrates the regfile write port between ALU writeback and a buffered load-writeback FIFO.
// ALU has priority, a starvation counter forces the FIFO through, and writes to R15 are dropped.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_we,
  input  logic [3:0]  alu_wa,
  input  logic [31:0] alu_wd,
  output logic        alu_stall,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_wa,
  input  logic [31:0] mem_wd,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic        pending,
  output logic        r15_drop
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {G_IDLE, G_ALU, G_FIFO, G_BYP} grant_e;

  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [SW-1:0]    starve_q;
  logic [DEPTH-1:0] kill_q, kill_next;
  logic [3:0]       ent_wa [DEPTH];
  logic [31:0]      ent_wd [DEPTH];

  grant_e      grant;
  logic        live, head_killed, accept, push, pop;
  logic [3:0]  sel_wa;
  logic [31:0] sel_wd;

  // Grant selection, port mux and FIFO control
  always_comb begin
    grant       = G_IDLE;
    sel_wa      = 4'h0;
    sel_wd      = 32'h0;
    live        = (cnt_q != '0) && !kill_q[head_q];
    head_killed = (cnt_q != '0) && kill_q[head_q];
    mem_ready   = (cnt_q < CW'(DEPTH)) && !reset;
    accept      = mem_valid && mem_ready;

    if (reset)                                        grant = G_IDLE;
    else if (live && (starve_q == SW'(STARVE_MAX)))   grant = G_FIFO;
    else if (alu_we)                                  grant = G_ALU;
    else if (live)                                    grant = G_FIFO;
    else if (accept && (cnt_q == '0))                 grant = G_BYP;

    case (grant)
      G_ALU:   begin sel_wa = alu_wa;         sel_wd = alu_wd;         end
      G_FIFO:  begin sel_wa = ent_wa[head_q]; sel_wd = ent_wd[head_q]; end
      G_BYP:   begin sel_wa = mem_wa;         sel_wd = mem_wd;         end
      default: begin sel_wa = 4'h0;           sel_wd = 32'h0;          end
    endcase

    r15_drop  = (grant != G_IDLE) && (sel_wa == 4'hF);
    we3       = (grant != G_IDLE) && (sel_wa != 4'hF);
    wa3       = sel_wa;
    wd3       = sel_wd;
    alu_stall = !reset && alu_we && (grant != G_ALU);
    pending   = (cnt_q != '0);

    push = accept && (grant != G_BYP);
    pop  = !reset && ((grant == G_FIFO) || head_killed);

    // A granted ALU write supersedes older buffered loads to the same register
    for (int unsigned i = 0; i < DEPTH; i++) begin
      kill_next[i] = kill_q[i] || ((grant == G_ALU) && (ent_wa[i] == alu_wa));
    end
    if (push) kill_next[tail_q] = (grant == G_ALU) && (mem_wa == alu_wa);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      starve_q <= '0;
      kill_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_wa[i] <= 4'h0;
    end else begin
      if (push) begin
        ent_wa[tail_q] <= mem_wa;
        tail_q         <= tail_q + PW'(1);
      end
      if (pop) head_q <= head_q + PW'(1);
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      kill_q <= kill_next;
      if ((grant == G_FIFO) || (cnt_q == '0))
        starve_q <= '0;
      else if ((grant == G_ALU) && live && (starve_q != SW'(STARVE_MAX)))
        starve_q <= starve_q + SW'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (!reset && push) ent_wd[tail_q] <= mem_wd;
  end

endmodule
